// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters, an
// optional static predict-not-taken mode, and resolution statistics.
// Lookup and mispredict/redirect are purely combinational; table and
// statistics state change on the rising edge of clk.
module branch_predictor #(
  parameter int PC_WIDTH    = 32,
  parameter int ENTRIES     = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int STATIC_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  lk_pc,
  output logic                 lk_taken,
  output logic [PC_WIDTH-1:0]  lk_target,
  input  logic                 upd_valid,
  input  logic                 upd_is_jump,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic                 upd_taken,
  input  logic [PC_WIDTH-1:0]  upd_target,
  input  logic                 upd_pred_taken,
  input  logic [PC_WIDTH-1:0]  upd_pred_target,
  output logic                 mispredict,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic [CNT_WIDTH-1:0] stat_branches,
  output logic [CNT_WIDTH-1:0] stat_mispredicts
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX - 2;
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  // Table state: small enough to live in registers, which keeps the
  // lookup path asynchronous as IF requires.
  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_d    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  logic [PC_WIDTH-1:0] target_d [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];

  logic [CNT_WIDTH-1:0] stat_branches_q, stat_branches_d;
  logic [CNT_WIDTH-1:0] stat_mispredicts_q, stat_mispredicts_d;

  logic [IDX-1:0]      lk_idx, upd_idx;
  logic [TAG_W-1:0]    lk_tag, upd_tag;
  logic                lk_hit, upd_hit;
  logic [1:0]          upd_ctr;
  logic                wr_en;
  logic [1:0]          wr_ctr;
  logic [PC_WIDTH-1:0] wr_target;

  // The two low PC bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

  assign lk_idx  = lk_pc[IDX+1:2];
  assign lk_tag  = lk_pc[PC_WIDTH-1:IDX+2];
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[PC_WIDTH-1:IDX+2];
  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr = ctr_q[upd_idx];

  // Lookup: predicted next PC for IF, from the registered table only.
  always_comb begin
    lk_taken  = (STATIC_MODE == 0) && lk_hit && ctr_q[lk_idx][1];
    lk_target = lk_taken ? target_q[lk_idx] : lk_pc + PC_STEP;
  end

  // Resolution: flag a wrong direction or wrong taken target and steer fetch.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (upd_valid) begin
      mispredict  = (upd_taken != upd_pred_taken) ||
                    (upd_taken && (upd_target != upd_pred_target));
      redirect_pc = upd_taken ? upd_target : upd_pc + PC_STEP;
    end
  end

  // Decide what the resolved instruction writes back to its entry, if anything.
  always_comb begin
    wr_en     = 1'b0;
    wr_ctr    = upd_ctr;
    wr_target = target_q[upd_idx];
    if (upd_valid && (STATIC_MODE == 0)) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_is_jump) begin
          wr_ctr    = 2'b11;
          wr_target = upd_target;
        end else if (upd_taken) begin
          wr_ctr    = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
          wr_target = upd_target;
        end else begin
          wr_ctr    = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocation simply evicts whatever aliased into this slot.
        wr_en     = 1'b1;
        wr_ctr    = upd_is_jump ? 2'b11 : 2'b10;
        wr_target = upd_target;
      end
    end
  end

  // Next-state for the table and the statistics counters.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      ctr_d[i]    = ctr_q[i];
    end
    if (wr_en) begin
      valid_d[upd_idx]  = 1'b1;
      tag_d[upd_idx]    = upd_tag;
      target_d[upd_idx] = wr_target;
      ctr_d[upd_idx]    = wr_ctr;
    end
    stat_branches_d    = stat_branches_q + CNT_WIDTH'(upd_valid);
    stat_mispredicts_d = stat_mispredicts_q + CNT_WIDTH'(mispredict);
  end

  // State registers; reset discards any update presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vector table, hand sequences for
// reset and static mode, and randomized traffic against a behavioural model.
module tb_branch_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Dynamic-mode instance
  logic        rst;
  logic [31:0] lk_pc;
  logic        lk_taken;
  logic [31:0] lk_target;
  logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches, stat_mispredicts;

  branch_predictor #(.PC_WIDTH(32), .ENTRIES(16), .CNT_WIDTH(32), .STATIC_MODE(0)) dut (
    .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_taken(lk_taken), .lk_target(lk_target),
    .upd_valid(upd_valid), .upd_is_jump(upd_is_jump), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // Static-mode instance with narrow statistics counters
  logic        s_rst;
  logic [31:0] s_lk_pc;
  logic        s_lk_taken;
  logic [31:0] s_lk_target;
  logic        s_upd_valid, s_upd_is_jump, s_upd_taken, s_upd_pred_taken;
  logic [31:0] s_upd_pc, s_upd_target, s_upd_pred_target;
  logic        s_mispredict;
  logic [31:0] s_redirect_pc;
  logic [3:0]  s_stat_branches, s_stat_mispredicts;

  branch_predictor #(.PC_WIDTH(32), .ENTRIES(16), .CNT_WIDTH(4), .STATIC_MODE(1)) dut_s (
    .clk(clk), .rst(s_rst), .lk_pc(s_lk_pc), .lk_taken(s_lk_taken), .lk_target(s_lk_target),
    .upd_valid(s_upd_valid), .upd_is_jump(s_upd_is_jump), .upd_pc(s_upd_pc),
    .upd_taken(s_upd_taken), .upd_target(s_upd_target), .upd_pred_taken(s_upd_pred_taken),
    .upd_pred_target(s_upd_pred_target), .mispredict(s_mispredict), .redirect_pc(s_redirect_pc),
    .stat_branches(s_stat_branches), .stat_mispredicts(s_stat_mispredicts)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int N = 16;
  bit        m_valid [N];
  bit [31:0] m_tag   [N];
  bit [31:0] m_tgt   [N];
  int        m_ctr   [N];
  bit [31:0] m_br, m_mis;

  function automatic int m_idx(input bit [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit [31:0] m_tagof(input bit [31:0] pc);
    return pc >> 6;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_br  = 0;
    m_mis = 0;
  endfunction

  function automatic bit m_hit(input bit [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic void m_predict(input bit [31:0] pc, output bit tk, output bit [31:0] tgt);
    tk  = m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    tgt = tk ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mispred(input bit uv, input bit ut, input bit [31:0] utgt,
                                   input bit upt, input bit [31:0] uptgt);
    return uv && ((ut != upt) || (ut && (utgt != uptgt)));
  endfunction

  function automatic void m_update(input bit uj, input bit [31:0] pc, input bit ut,
                                   input bit [31:0] tgt, input bit mis);
    int i;
    i = m_idx(pc);
    m_br = m_br + 1;
    if (mis) m_mis = m_mis + 1;
    if (m_hit(pc)) begin
      if (uj) begin
        m_ctr[i] = 3;
        m_tgt[i] = tgt;
      end else if (ut) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (ut) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = m_tagof(pc);
      m_tgt[i]   = tgt;
      m_ctr[i]   = uj ? 3 : 2;
    end
  endfunction

  // One randomized cycle: predict from the model, compare at negedge, then advance.
  task automatic model_cycle(input int n);
    bit        etk, emis;
    bit [31:0] etgt, ered;
    m_predict(lk_pc, etk, etgt);
    emis = m_mispred(upd_valid, upd_taken, upd_target, upd_pred_taken, upd_pred_target);
    ered = upd_valid ? (upd_taken ? upd_target : upd_pc + 32'd4) : 32'd0;
    @(negedge clk);
    $display("rnd %0d rst=%0b lk=%h tk=%0b tgt=%h upd=%0b pc=%h mis=%0b", n, rst, lk_pc,
             lk_taken, lk_target, upd_valid, upd_pc, mispredict);
    check("rnd_lk_taken", 32'(lk_taken), 32'(etk));
    check("rnd_lk_target", lk_target, etgt);
    check("rnd_mispredict", 32'(mispredict), 32'(emis));
    check("rnd_redirect", redirect_pc, ered);
    check("rnd_stat_br", stat_branches, m_br);
    check("rnd_stat_mis", stat_mispredicts, m_mis);
    @(posedge clk);
    if (!rst) m_reset();
    else if (upd_valid) m_update(upd_is_jump, upd_pc, upd_taken, upd_target, emis);
    #1;
  endtask

  function automatic bit [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
    return 32'h8000_0000 + (32'($urandom_range(0, 47)) << 2);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] lk;
    logic        uv, uj;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic        e_mis;
    logic [31:0] e_red;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] lk, input logic uv, input logic uj,
                              input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                              input logic upt, input logic [31:0] uptgt, input logic e_tk,
                              input logic [31:0] e_tgt, input logic e_mis, input logic [31:0] e_red);
    vec_t v;
    v.lk = lk; v.uv = uv; v.uj = uj; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.upt = upt; v.uptgt = uptgt; v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_mis = e_mis; v.e_red = e_red;
    return v;
  endfunction

  function automatic vec_t lk_only(input logic [31:0] lk, input logic e_tk, input logic [31:0] e_tgt);
    return mk(lk, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, e_tk, e_tgt, 0, 32'h0);
  endfunction

  task automatic idle_main();
    upd_valid = 0; upd_is_jump = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
  endtask

  int exp_br, exp_mis;

  initial begin
    // cold lookup, allocate/hit, counter hysteresis and saturation
    vecs.push_back(lk_only(32'h8000_0000, 0, 32'h8000_0004));
    vecs.push_back(mk(32'h8000_0010, 1, 0, 32'h8000_0010, 1, 32'h8000_0040, 0, 32'h0, 0, 32'h8000_0014, 1, 32'h8000_0040));
    vecs.push_back(lk_only(32'h8000_0010, 1, 32'h8000_0040));
    vecs.push_back(mk(32'h8000_0010, 1, 0, 32'h8000_0010, 0, 32'h0, 1, 32'h8000_0040, 1, 32'h8000_0040, 1, 32'h8000_0014));
    vecs.push_back(lk_only(32'h8000_0010, 0, 32'h8000_0014));
    vecs.push_back(mk(32'h8000_0010, 1, 0, 32'h8000_0010, 1, 32'h8000_0040, 0, 32'h0, 0, 32'h8000_0014, 1, 32'h8000_0040));
    vecs.push_back(lk_only(32'h8000_0010, 1, 32'h8000_0040));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(32'h8000_0010, 1, 0, 32'h8000_0010, 1, 32'h8000_0040, 1, 32'h8000_0040, 1, 32'h8000_0040, 0, 32'h8000_0040));
    vecs.push_back(mk(32'h8000_0010, 1, 0, 32'h8000_0010, 0, 32'h0, 1, 32'h8000_0040, 1, 32'h8000_0040, 1, 32'h8000_0014));
    vecs.push_back(lk_only(32'h8000_0010, 1, 32'h8000_0040));
    // jump allocate, then target change on a hit
    vecs.push_back(mk(32'h8000_0020, 1, 1, 32'h8000_0020, 1, 32'h8000_0100, 0, 32'h0, 0, 32'h8000_0024, 1, 32'h8000_0100));
    vecs.push_back(mk(32'h8000_0020, 1, 1, 32'h8000_0020, 1, 32'h8000_0200, 1, 32'h8000_0100, 1, 32'h8000_0100, 1, 32'h8000_0200));
    vecs.push_back(lk_only(32'h8000_0020, 1, 32'h8000_0200));
    // aliasing eviction with same-cycle lookup of the old occupant
    vecs.push_back(mk(32'h8000_0010, 1, 0, 32'h8000_0050, 1, 32'h8000_0300, 0, 32'h0, 1, 32'h8000_0040, 1, 32'h8000_0300));
    vecs.push_back(lk_only(32'h8000_0010, 0, 32'h8000_0014));
    vecs.push_back(lk_only(32'h8000_0050, 1, 32'h8000_0300));
    // PC+4 wrap, and idle outputs with junk update fields
    vecs.push_back(mk(32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 32'h1234_5678, 0, 32'h0, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk(32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0));
    // saturation at strong-not-taken
    vecs.push_back(mk(32'h8000_0050, 1, 0, 32'h8000_0050, 0, 32'h0, 0, 32'h0, 1, 32'h8000_0300, 0, 32'h8000_0054));
    vecs.push_back(mk(32'h8000_0050, 1, 0, 32'h8000_0050, 0, 32'h0, 0, 32'h0, 0, 32'h8000_0054, 0, 32'h8000_0054));
    vecs.push_back(mk(32'h8000_0050, 1, 0, 32'h8000_0050, 0, 32'h0, 0, 32'h0, 0, 32'h8000_0054, 0, 32'h8000_0054));
    vecs.push_back(mk(32'h8000_0050, 1, 0, 32'h8000_0050, 1, 32'h8000_0300, 0, 32'h0, 0, 32'h8000_0054, 1, 32'h8000_0300));
    vecs.push_back(lk_only(32'h8000_0050, 0, 32'h8000_0054));

    // ---- reset, both instances ----
    rst = 0; s_rst = 0;
    lk_pc = 32'h8000_0000;
    idle_main();
    s_lk_pc = 0; s_upd_valid = 0; s_upd_is_jump = 0; s_upd_pc = 0; s_upd_taken = 0;
    s_upd_target = 0; s_upd_pred_taken = 0; s_upd_pred_target = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    check("reset_stat_br", stat_branches, 32'd0);
    check("reset_stat_mis", stat_mispredicts, 32'd0);
    check("reset_mispredict", 32'(mispredict), 32'd0);
    @(posedge clk);
    #1;

    // ---- directed table ----
    exp_br = 0;
    exp_mis = 0;
    foreach (vecs[i]) begin
      lk_pc = vecs[i].lk; upd_valid = vecs[i].uv; upd_is_jump = vecs[i].uj;
      upd_pc = vecs[i].upc; upd_taken = vecs[i].ut; upd_target = vecs[i].utgt;
      upd_pred_taken = vecs[i].upt; upd_pred_target = vecs[i].uptgt;
      if (vecs[i].uv) exp_br++;
      if (vecs[i].e_mis) exp_mis++;
      @(negedge clk);
      $display("vec %0d lk=%h tk=%0b tgt=%h mis=%0b red=%h", i, lk_pc, lk_taken, lk_target,
               mispredict, redirect_pc);
      check($sformatf("vec%0d_lk_taken", i), 32'(lk_taken), 32'(vecs[i].e_tk));
      check($sformatf("vec%0d_lk_target", i), lk_target, vecs[i].e_tgt);
      check($sformatf("vec%0d_mispredict", i), 32'(mispredict), 32'(vecs[i].e_mis));
      check($sformatf("vec%0d_redirect", i), redirect_pc, vecs[i].e_red);
      @(posedge clk);
      #1;
    end
    idle_main();
    #1;
    check("table_stat_br", stat_branches, 32'(exp_br));
    check("table_stat_mis", stat_mispredicts, 32'(exp_mis));

    // ---- reset with a same-cycle update that must be dropped ----
    rst = 0;
    upd_valid = 1; upd_pc = 32'h8000_0070; upd_taken = 1; upd_target = 32'h8000_0900;
    @(posedge clk);
    #1;
    rst = 1;
    idle_main();
    lk_pc = 32'h8000_0070;
    @(negedge clk);
    $display("rst_drop lk=%h tk=%0b tgt=%h", lk_pc, lk_taken, lk_target);
    check("rst_drop_taken", 32'(lk_taken), 32'd0);
    check("rst_drop_target", lk_target, 32'h8000_0074);
    check("rst_drop_stat_br", stat_branches, 32'd0);
    lk_pc = 32'h8000_0020;
    #1;
    check("rst_clear_taken", 32'(lk_taken), 32'd0);
    check("rst_clear_target", lk_target, 32'h8000_0024);
    @(posedge clk);
    #1;
    m_reset();

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 1000; n++) begin
      bit        pt;
      bit [31:0] pg;
      rst         = ($urandom_range(0, 299) != 0);
      lk_pc       = rand_pc();
      upd_valid   = ($urandom_range(0, 3) != 0);
      upd_is_jump = ($urandom_range(0, 4) == 0);
      upd_pc      = rand_pc();
      upd_taken   = upd_is_jump ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
      upd_target  = rand_pc();
      if ($urandom_range(0, 2) != 0) begin
        m_predict(upd_pc, pt, pg);
        upd_pred_taken  = pt;
        upd_pred_target = pg;
      end else begin
        upd_pred_taken  = 1'($urandom_range(0, 1));
        upd_pred_target = rand_pc();
      end
      model_cycle(n);
    end
    rst = 1;
    idle_main();

    // ---- static mode: 17 updates, first 7 taken ----
    #1;
    check("s_reset_stat_br", 32'(s_stat_branches), 32'd0);
    check("s_reset_stat_mis", 32'(s_stat_mispredicts), 32'd0);
    s_rst = 1;
    for (int k = 0; k < 17; k++) begin
      s_lk_pc = 32'h8000_0010; s_upd_valid = 1; s_upd_is_jump = 0; s_upd_pc = 32'h8000_0010;
      s_upd_taken = (k < 7); s_upd_target = 32'h8000_0040;
      s_upd_pred_taken = 0; s_upd_pred_target = 32'h0;
      @(negedge clk);
      $display("static %0d tk=%0b mis=%0b red=%h lk_tk=%0b", k, s_upd_taken, s_mispredict,
               s_redirect_pc, s_lk_taken);
      check("s_mispredict", 32'(s_mispredict), 32'(k < 7));
      check("s_redirect", s_redirect_pc, (k < 7) ? 32'h8000_0040 : 32'h8000_0014);
      check("s_lk_taken", 32'(s_lk_taken), 32'd0);
      check("s_lk_target", s_lk_target, 32'h8000_0014);
      @(posedge clk);
      #1;
      if (k == 9) begin
        check("s_stat_br_10", 32'(s_stat_branches), 32'd10);
        check("s_stat_mis_7", 32'(s_stat_mispredicts), 32'd7);
      end
    end
    s_upd_valid = 0;
    check("s_stat_br_wrap", 32'(s_stat_branches), 32'd1);
    check("s_stat_mis_final", 32'(s_stat_mispredicts), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

- Parametrised dynamic branch predictor for the 5-stage pipeline.
- Replaces the fixed predict-not-taken / flush-on-taken scheme.
- Lookup side: IF sees a predicted next PC in the same cycle.
- Update side: EXE resolves each branch/jump, updates the table, and raises a flush-and-redirect when the prediction was wrong.
- Contents: a direct-mapped BTB with 2-bit saturating counters, a legacy static mode, and resolution statistics counters.

## Interface

Parameters:
- PC_WIDTH, 32, PC/target width.
- ENTRIES, 16, BTB entries; power of two, 2..256.
- CNT_WIDTH, 32, statistics counter width.
- STATIC_MODE, 0, 1 = always predict not-taken; table never written; flush on every taken resolution.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- lk_pc  in  PC_WIDTH  IF-stage PC to predict.
- lk_taken  out  1  prediction is taken (combinational).
- lk_target  out  PC_WIDTH  predicted next PC (combinational).
- upd_valid  in  1  EXE holds a resolved control-transfer instruction this cycle.
- upd_is_jump  in  1  instruction is JAL/JALR (unconditional).
- upd_pc  in  PC_WIDTH  PC of resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_WIDTH  actual taken target.
- upd_pred_taken  in  1  prediction carried down the pipe.
- upd_pred_target  in  PC_WIDTH  predicted target carried down the pipe.
- mispredict  out  1  flush IF/ID, ID/EXE, EXE/MEM (combinational).
- redirect_pc  out  PC_WIDTH  PC to load when mispredict=1.
- stat_branches  out  CNT_WIDTH  count of upd_valid cycles.
- stat_mispredicts  out  CNT_WIDTH  count of mispredict cycles.

## Operation

**Indexing**
- IDX = log2(ENTRIES).
- index = pc[IDX+1:2].
- tag = pc[PC_WIDTH-1:IDX+2].

**Entry contents**
- valid, tag, target, ctr[1:0].
- ctr encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

**Lookup**
- hit = valid && tag match.
- lk_taken = hit && ctr[1]; forced 0 when STATIC_MODE=1.
- lk_target = lk_taken ? entry.target : lk_pc+4 (mod 2^PC_WIDTH).

**Mispredict detection**
- mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4.
- With upd_valid=0, both outputs are 0.

**Table update** (on clock edge when upd_valid=1 and STATIC_MODE=0)
- Hit, jump: ctr←11, target←upd_target.
- Hit, branch taken: ctr saturating +1, target←upd_target.
- Hit, branch not taken: ctr saturating −1; target unchanged.
- Miss, taken: allocate (overwrite any occupant): valid←1, tag, target←upd_target, ctr←11 if jump else 10.
- Miss, not taken: no write.

**Statistics**
- stat_branches increments on every upd_valid.
- stat_mispredicts increments on every mispredict.
- Both wrap modulo 2^CNT_WIDTH; both keep counting in STATIC_MODE.

**Reset** (rst=0 at a rising edge)
- All valid←0, all ctr←01, both stat counters←0.
- Tag/target contents are don't-care.
- An update presented in the same cycle as reset is discarded.

## Timing

**Latency**
- Lookup and mispredict/redirect are zero-latency combinational paths.
- Table and counter writes take effect at the next rising edge.
- A lookup in cycle N sees updates from cycles ≤ N−1.
- Same-cycle lookup and update to the same index returns the pre-update entry. No bypass.

**Post-reset outputs**
- lk_taken=0, lk_target=lk_pc+4.
- mispredict=0 unless upd_valid=1.
- stat_*=0.

**Handshake**
- No handshake: upd_valid is a single-cycle qualifier, at most one update per cycle.
- Pipeline stalls must deassert upd_valid; a repeated update is counted and applied twice.
- Pipeline flush priority is owned by the top level. mispredict takes precedence over hazard stall in the PC mux.

**Boundary cases**
- Counter saturation holds at 00 and 11.
- PC+4 wraps to 0 at 2^PC_WIDTH−4.
- Aliasing PCs (same index, different tag) evict each other; this is not an error.

## Test plan

1. **Reset / cold lookup:** hold rst=0 for 2 cycles, release → lk_pc=0x80000000 gives lk_taken=0, lk_target=0x80000004; stat_*=0.
2. **Allocate then hit:** update pc=0x80000010, taken, target=0x80000040, pred_taken=0 → mispredict=1, redirect_pc=0x80000040. Next cycle, lookup 0x80000010 → lk_taken=1, lk_target=0x80000040.
3. **Counter hysteresis:** after case 2 (ctr=10), resolve not-taken with pred_taken=1 → mispredict=1, redirect_pc=0x80000014, ctr=01, next lookup not taken. Then a taken update → ctr=10 → predicted taken again. Four taken updates leave ctr at 11.
4. **Target change:** jump hit at 0x80000020 with pred_target=0x80000100 but actual 0x80000200 → mispredict=1, redirect_pc=0x80000200; next lookup target=0x80000200.
5. **Aliasing / same-cycle:** ENTRIES=16, update 0x80000010 and look up 0x80000010 in the same cycle → old value returned. Then allocate 0x80000050 (same index) → lookup 0x80000010 misses.
6. **STATIC_MODE=1:** any taken update → mispredict=1 and lk_taken stays 0. After 10 updates, 7 of them taken → stat_branches=10, stat_mispredicts=7. With CNT_WIDTH=4, 17 updates → stat_branches=1.
